// File: rtl/fb_pkg.sv
// Shared types, defaults and address helper for the frame-buffer arbiter.
package fb_pkg;

    localparam int unsigned FB_H_RES  = 640;
    localparam int unsigned FB_V_RES  = 480;
    localparam int unsigned FB_ADDR_W = 19;

    typedef logic [2:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } fsm_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        rgb_t       rgb;
    } wr_entry_t;

    function automatic logic [31:0] xy_to_addr(input logic [9:0] x, input logic [9:0] y,
                                               input int unsigned h_res);
        return 32'(y) * h_res + 32'(x);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding pending draw-side pixel writes.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wr_entry_t i_data,
    input  logic      i_pop,
    output wr_entry_t o_data,
    output logic      o_full,
    output logic      o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    wr_entry_t        r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads win, buffered draw writes and
// whole-buffer clears are committed only during blanking.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned H_RES      = FB_H_RES,
    parameter int unsigned V_RES      = FB_V_RES,
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              activeVideo,
    output logic              r,
    output logic              g,
    output logic              b,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [2:0]        wr_rgb,
    input  logic              clr_req,
    input  logic [2:0]        clr_rgb,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    fsm_t              r_state;
    fsm_t              w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    rgb_t              r_clr_rgb;
    logic              r_clr_busy;
    logic              r_av_d;
    wr_entry_t         w_head;
    wr_entry_t         w_wr_entry;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_disp_addr;
    logic [ADDR_W-1:0] w_head_addr;

    assign wr_ready    = ~w_full & ~r_clr_busy;
    assign clr_busy    = r_clr_busy;
    assign w_push      = wr_valid & wr_ready;
    assign w_wr_entry  = '{x: wr_x, y: wr_y, rgb: wr_rgb};
    assign w_disp_addr = ADDR_W'(xy_to_addr(x, y, H_RES));
    assign w_head_addr = ADDR_W'(xy_to_addr(w_head.x, w_head.y, H_RES));
    assign w_in_range  = (32'(w_head.x) < H_RES) && (32'(w_head.y) < V_RES);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // An IDLE state with a freshly pushed entry pops at once, so a write can
    // reach the RAM the cycle right after it is accepted.
    always_comb begin
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        if (activeVideo) begin
            mem_addr = w_disp_addr;
        end else begin
            unique case (r_state)
                IDLE, DRAIN: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = DRAIN;
                        if (w_in_range) begin
                            mem_addr  = w_head_addr;
                            mem_we    = 1'b1;
                            mem_wdata = w_head.rgb;
                        end
                    end else begin
                        w_state_nxt = r_clr_busy ? CLEAR : IDLE;
                    end
                end
                CLEAR: begin
                    mem_addr  = r_clr_cnt;
                    mem_we    = 1'b1;
                    mem_wdata = r_clr_rgb;
                    if (r_clr_cnt == LAST_ADDR) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_clr_rgb  <= '0;
            r_clr_busy <= 1'b0;
            r_av_d     <= 1'b0;
            r         <= 1'b0;
            g         <= 1'b0;
            b         <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_av_d    <= activeVideo;
            {r, g, b} <= r_av_d ? mem_rdata : 3'b000;
            if (clr_req && !r_clr_busy) begin
                r_clr_busy <= 1'b1;
                r_clr_rgb  <= clr_rgb;
            end
            if (!activeVideo && r_state == CLEAR) begin
                if (r_clr_cnt == LAST_ADDR) begin
                    r_clr_cnt  <= '0;
                    r_clr_busy <= 1'b0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: random traffic against a queue-based model.
module tb_fb_arbiter;
    localparam int unsigned H     = 640;
    localparam int unsigned V     = 4;
    localparam int unsigned AW    = 19;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NPIX  = H * V;

    logic          clk;
    logic          rst;
    logic [9:0]    x, y;
    logic          activeVideo;
    logic          r, g, b;
    logic          wr_valid, wr_ready;
    logic [9:0]    wr_x, wr_y;
    logic [2:0]    wr_rgb;
    logic          clr_req;
    logic [2:0]    clr_rgb;
    logic          clr_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [2:0]    mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int occ = 0;
    int av_we_cnt = 0;
    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];
    int          obs_cyc[$];
    logic [2:0]  ram [NPIX];
    int          ram_idx;

    fb_arbiter #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .activeVideo (activeVideo),
        .r           (r),
        .g           (g),
        .b           (b),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_rgb      (wr_rgb),
        .clr_req     (clr_req),
        .clr_rgb     (clr_rgb),
        .clr_busy    (clr_busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM: one-cycle registered read.
    assign ram_idx = int'(mem_addr);
    always @(posedge clk) begin
        if (mem_we && ram_idx < NPIX) ram[ram_idx] <= mem_wdata;
        mem_rdata <= (ram_idx < NPIX) ? ram[ram_idx] : 3'b000;
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            obs_q.push_back({mem_addr, mem_wdata});
            obs_cyc.push_back(cyc);
            if (activeVideo) av_we_cnt++;
        end
    end

    function automatic logic in_range(input logic [9:0] px, input logic [9:0] py);
        return (int'(px) < H) && (int'(py) < V);
    endfunction

    function automatic logic [21:0] exp_word(input logic [9:0] px, input logic [9:0] py,
                                             input logic [2:0] c);
        logic [31:0] a;
        a = 32'(py) * H + 32'(px);
        return {a[18:0], c};
    endfunction

    function automatic int first_diff(input int base);
        int n = obs_q.size() - base;
        for (int i = 0; i < exp_q.size() && i < n; i++)
            if (obs_q[base + i] !== exp_q[i]) return i;
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    // Model: one pop per blanking cycle while anything is queued; accepted
    // in-range entries become expected RAM writes in order.
    task automatic model_step(input logic av, input logic acc, input logic [9:0] px,
                              input logic [9:0] py, input logic [2:0] c);
        if (!av && occ > 0) occ--;
        if (acc) begin
            occ++;
            if (in_range(px, py)) exp_q.push_back(exp_word(px, py, c));
        end
    endtask

    task automatic clock_cycle(input logic av, input logic vld, input logic [9:0] px,
                               input logic [9:0] py, input logic [2:0] c,
                               output logic rdy, output logic bsy);
        activeVideo = av;
        wr_valid    = vld;
        wr_x        = px;
        wr_y        = py;
        wr_rgb      = c;
        @(negedge clk);
        rdy = wr_ready;
        bsy = clr_busy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        logic rdy, bsy, er;
        logic [9:0] px, py;
        logic [2:0] c;
        int base;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({r, g, b, mem_we, mem_addr, mem_wdata, clr_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0",
                     {r, g, b, mem_we, mem_addr, mem_wdata, clr_busy});
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b required=1", wr_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            px = 10'($urandom_range(0, H - 1));
            py = 10'($urandom_range(0, V - 1));
            c  = 3'($urandom);
            er = (occ < DEPTH);
            clock_cycle(1'b1, 1'b1, px, py, c, rdy, bsy);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL reset_fill_ready i=%0d got=%b required=%b", i, rdy, er);
            end
            model_step(1'b1, er, px, py, c);
        end
        clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        base = obs_q.size();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({r, g, b, mem_we, mem_addr, mem_wdata, clr_busy, wr_ready} !== 27'd1) begin
            errors++;
            $display("FAIL reset_mid_drain got=%h required=1",
                     {r, g, b, mem_we, mem_addr, mem_wdata, clr_busy, wr_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        occ = 0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        checks++;
        if (obs_q.size() != base || rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_queue_dropped writes=%0d ready=%b required writes=0 ready=1",
                     obs_q.size() - base, rdy);
        end
    endtask

    task automatic test_single_write;
        logic rdy, bsy;
        clock_cycle(1'b0, 1'b1, 10'd5, 10'd2, 3'b101, rdy, bsy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got=%b required=1", rdy);
        end
        model_step(1'b0, 1'b1, 10'd5, 10'd2, 3'b101);
        activeVideo = 1'b0;
        wr_valid    = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 19'd1285, 3'b101}) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%0d data=%b required we=1 addr=1285 data=101",
                     mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        cyc++;
        model_step(1'b0, 1'b0, 10'd0, 10'd0, 3'd0);
        exp_q.delete();
        x = 10'd5;
        y = 10'd2;
        activeVideo = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_addr !== 19'd1285 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL display_addr got addr=%0d we=%b required addr=1285 we=0",
                     mem_addr, mem_we);
        end
        @(posedge clk);
        #1;
        cyc++;
        clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 3'b101) begin
            errors++;
            $display("FAIL display_pixel got=%b required=101", {r, g, b});
        end
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 3'b000) begin
            errors++;
            $display("FAIL display_blank got=%b required=000", {r, g, b});
        end
        @(posedge clk);
        #1;
        cyc++;
        x = 10'd0;
        y = 10'd0;
    endtask

    task automatic test_fifo_full;
        logic rdy, bsy, er;
        logic [9:0] ex [5];
        logic [9:0] ey [5];
        logic [2:0] ec [5];
        int base, k, t_fall, d, bad;
        base = obs_q.size();
        exp_q.delete();
        k = 0;
        for (int i = 0; i < 5; i++) begin
            ex[i] = 10'($urandom_range(0, H - 1));
            ey[i] = 10'($urandom_range(0, V - 1));
            ec[i] = 3'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            er = (occ < DEPTH);
            clock_cycle(1'b1, 1'b1, ex[k], ey[k], ec[k], rdy, bsy);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL full_ready i=%0d got=%b required=%b", i, rdy, er);
            end
            model_step(1'b1, er, ex[k], ey[k], ec[k]);
            if (er && k < 4) k++;
        end
        checks++;
        if (obs_q.size() != base) begin
            errors++;
            $display("FAIL full_no_write_active writes=%0d required=0", obs_q.size() - base);
        end
        t_fall = cyc;
        for (int i = 0; i < 6; i++) begin
            er = (occ < DEPTH);
            clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL drain_ready i=%0d got=%b required=%b", i, rdy, er);
            end
            model_step(1'b0, 1'b0, 10'd0, 10'd0, 3'd0);
        end
        d = first_diff(base);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL full_drain_order idx=%0d got=%h required=%h", d, obs_q[base + d], exp_q[d]);
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (base + i >= obs_cyc.size() || obs_cyc[base + i] != t_fall + i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_drain_consecutive late_writes=%0d required=0", bad);
        end
    endtask

    task automatic test_back_to_back;
        logic rdy, bsy, er, av;
        logic [9:0] px, py;
        logic [2:0] c;
        int base, d, acc;
        base = obs_q.size();
        exp_q.delete();
        acc = 0;
        px = 10'($urandom_range(0, H - 1));
        py = 10'($urandom_range(0, V - 1));
        c  = 3'($urandom);
        for (int i = 0; i < 20; i++) begin
            av = (i < 6);
            er = (occ < DEPTH);
            clock_cycle(av, acc < 10, px, py, c, rdy, bsy);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL b2b_ready i=%0d got=%b required=%b", i, rdy, er);
            end
            model_step(av, er && acc < 10, px, py, c);
            if (er && acc < 10) begin
                acc++;
                px = 10'($urandom_range(0, H - 1));
                py = 10'($urandom_range(0, V - 1));
                c  = 3'($urandom);
            end
        end
        d = first_diff(base);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL b2b_order idx=%0d got=%h required=%h", d, obs_q[base + d], exp_q[d]);
        end
    endtask

    task automatic test_out_of_range;
        logic rdy, bsy;
        int base, d;
        base = obs_q.size();
        exp_q.delete();
        clock_cycle(1'b0, 1'b1, 10'd700, 10'd10, 3'b111, rdy, bsy);
        model_step(1'b0, 1'b1, 10'd700, 10'd10, 3'b111);
        clock_cycle(1'b0, 1'b1, 10'd3, 10'd500, 3'b110, rdy, bsy);
        model_step(1'b0, 1'b1, 10'd3, 10'd500, 3'b110);
        clock_cycle(1'b0, 1'b1, 10'd1, 10'd1, 3'b011, rdy, bsy);
        model_step(1'b0, 1'b1, 10'd1, 10'd1, 3'b011);
        for (int i = 0; i < 4; i++) begin
            clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
            model_step(1'b0, 1'b0, 10'd0, 10'd0, 3'd0);
        end
        d = first_diff(base);
        checks++;
        if (d >= 0 || obs_q.size() - base != 1) begin
            errors++;
            $display("FAIL out_of_range writes=%0d idx=%0d got=%h required=1 write %h",
                     obs_q.size() - base, d, obs_q[base], exp_word(10'd1, 10'd1, 3'b011));
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range_ready got=%b required=1", rdy);
        end
    endtask

    task automatic test_random_traffic;
        logic rdy, bsy, er, av, have;
        logic [9:0] px, py;
        logic [2:0] c;
        int base, d, av0;
        base = obs_q.size();
        av0  = av_we_cnt;
        exp_q.delete();
        have = 1'b0;
        px = '0;
        py = '0;
        c  = '0;
        for (int i = 0; i < 420; i++) begin
            av = (i < 400) && ($urandom_range(0, 99) < 55);
            if (!have && i < 400 && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                px = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(630, 1023))
                                                 : 10'($urandom_range(0, H - 1));
                py = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(V, 1023))
                                                 : 10'($urandom_range(0, V - 1));
                c  = 3'($urandom);
            end
            er = (occ < DEPTH);
            clock_cycle(av, have, px, py, c, rdy, bsy);
            checks++;
            if (rdy !== er) begin
                errors++;
                $display("FAIL rand_ready i=%0d got=%b required=%b", i, rdy, er);
            end
            model_step(av, have && er, px, py, c);
            if (have && er) have = 1'b0;
        end
        d = first_diff(base);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL rand_writes idx=%0d got=%h required=%h n_got=%0d n_req=%0d",
                     d, obs_q[base + d], exp_q[d], obs_q.size() - base, exp_q.size());
        end
        checks++;
        if (av_we_cnt != av0) begin
            errors++;
            $display("FAIL rand_we_in_active got=%0d required=0", av_we_cnt - av0);
        end
    endtask

    task automatic test_clear;
        logic rdy, bsy, av, done;
        logic [9:0] px, py;
        logic [2:0] c;
        int base, d, viol, t_idle, av0;
        base = obs_q.size();
        av0  = av_we_cnt;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            px = 10'($urandom_range(0, H - 1));
            py = 10'($urandom_range(0, V - 1));
            c  = 3'($urandom);
            clock_cycle(1'b1, 1'b1, px, py, c, rdy, bsy);
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL clear_prefill_ready i=%0d got=%b required=1", i, rdy);
            end
            model_step(1'b1, 1'b1, px, py, c);
        end
        clr_req = 1'b1;
        clr_rgb = 3'b010;
        clock_cycle(1'b1, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        clr_req = 1'b0;
        for (int a = 0; a < NPIX; a++) exp_q.push_back({19'(a), 3'b010});
        done   = 1'b0;
        viol   = 0;
        t_idle = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            av      = (i % 40) < 25;
            clr_req = (i == 300);
            clr_rgb = (i == 300) ? 3'b111 : 3'b010;
            clock_cycle(av, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
            if (i == 0) begin
                checks++;
                if (bsy !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_busy_set got=%b required=1", bsy);
                end
            end
            if (bsy && rdy) viol++;
            if (!bsy) begin
                done   = 1'b1;
                t_idle = cyc - 1;
            end
        end
        clr_req = 1'b0;
        occ = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL clear_timeout busy still high after 20000 cycles, required low");
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL clear_ready_low cycles_ready_high=%0d required=0", viol);
        end
        d = first_diff(base);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL clear_writes idx=%0d got=%h required=%h n_got=%0d n_req=%0d",
                     d, obs_q[base + d], exp_q[d], obs_q.size() - base, exp_q.size());
        end
        checks++;
        if (obs_cyc.size() == 0 || obs_cyc[obs_cyc.size() - 1] != t_idle - 1) begin
            errors++;
            $display("FAIL clear_busy_fall busy_low_cycle=%0d required=last_write_cycle+1",
                     t_idle);
        end
        checks++;
        if (av_we_cnt != av0) begin
            errors++;
            $display("FAIL clear_we_in_active got=%0d required=0", av_we_cnt - av0);
        end
        x = 10'd5;
        y = 10'd2;
        clock_cycle(1'b1, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        clock_cycle(1'b0, 1'b0, 10'd0, 10'd0, 3'd0, rdy, bsy);
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 3'b010) begin
            errors++;
            $display("FAIL clear_readback got=%b required=010", {r, g, b});
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready_after got=%b required=1", wr_ready);
        end
    endtask

    initial begin
        rst         = 1'b0;
        activeVideo = 1'b0;
        x           = '0;
        y           = '0;
        wr_valid    = 1'b0;
        wr_x        = '0;
        wr_y        = '0;
        wr_rgb      = '0;
        clr_req     = 1'b0;
        clr_rgb     = '0;
        test_reset();
        test_single_write();
        test_fifo_full();
        test_back_to_back();
        test_out_of_range();
        test_random_traffic();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
